// File: rtl/leaf_tx_ni.sv
// Leaf network-interface transmitter: core words -> FIFO -> 4-phase bundled-data channel.
// Optional ack-rise timeout with sticky tx_err is enabled by defining TX_TIMEOUT_EN.
module leaf_tx_ni #(
    parameter int WIDTH   = 11,
    parameter int ADDR_W  = 3,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_W-1:0]       in_route,
    input  logic [WIDTH-ADDR_W-1:0] in_payload,
    output logic [WIDTH-1:0]        ch_data,
    output logic                    ch_req,
    input  logic                    ch_ack,
    output logic [15:0]             tx_count,
    output logic                    tx_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("leaf_tx_ni: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ack_meta, ack_s;
    state_t           state, state_next;
    logic             push, pop, load;

    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= ch_ack;
            ack_s    <= ack_meta;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: if (count != '0) begin
                load       = 1'b1;
                state_next = REQ;
            end
            REQ:  if (ack_s) state_next = REL;
            REL:  if (!ack_s) begin
                pop        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ch_req is a dedicated flop so the asynchronous router never sees decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ch_req <= 1'b0;
        end else begin
            state  <= state_next;
            ch_req <= (state_next == REQ);
        end
    end

    // NOTE: the storage array has no reset; occupancy gates every read, so stale words are never used.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_route, in_payload};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Data is captured only when leaving IDLE, keeping it stable for the whole handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_data  <= '0;
            tx_count <= '0;
        end else begin
            if (load) ch_data  <= mem[rd_ptr];
            if (pop)  tx_count <= tx_count + 16'd1;
        end
    end

`ifdef TX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counter saturates at TIMEOUT; the error fires on the edge it gets there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            tx_err  <= 1'b0;
        end else if (load) begin
            tmo_cnt <= '0;
        end else if (state == REQ && !ack_s && tmo_cnt != TMO_W'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_cnt == TMO_W'(TIMEOUT - 1)) tx_err <= 1'b1;
        end
    end
`else
    assign tx_err = 1'b0;
`endif

endmodule

// File: tb/tb_leaf_tx_ni.sv
// Self-checking bench for leaf_tx_ni: directed scenarios plus a randomized asynchronous-ack run,
// scored against an in-order packet queue and a packet-count model.
module tb_leaf_tx_ni;

    localparam int WIDTH   = 11;
    localparam int ADDR_W  = 3;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;
    localparam int PW      = WIDTH - ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_route = '0;
    logic [PW-1:0]     in_payload = '0;
    logic [WIDTH-1:0]  ch_data;
    logic              ch_req;
    logic              ch_ack;
    logic              resp_ack = 1'b0;
    logic              man_ack = 1'b0;
    logic [15:0]       tx_count;
    logic              tx_err;

    assign ch_ack = resp_ack | man_ack;

    leaf_tx_ni #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_route(in_route), .in_payload(in_payload),
        .ch_data(ch_data), .ch_req(ch_req), .ch_ack(ch_ack),
        .tx_count(tx_count), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    int               seen = 0;
    int               exp_tx = 0;
    bit               ack_block = 1'b1;
    bit               async_mode = 1'b0;
    int               ack_dly = 2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resp_delay();
        if (async_mode) #($urandom_range(1, 37));
        else begin
            repeat (ack_dly) @(posedge clk);
            #1;
        end
    endtask

    // Router-side responder: scores each delivered packet against the push order.
    initial begin
        logic [31:0] e;
        forever begin
            wait (ch_req === 1'b1 && !ack_block);
            #1;
            e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hxxxx_xxxx;
            check("resp_data", 32'(ch_data), e);
            seen++;
            resp_delay();
            resp_ack = 1'b1;
            wait (ch_req === 1'b0);
            resp_delay();
            resp_ack = 1'b0;
        end
    end

    // Bundling rule: ch_data may only change on the edge where ch_req rises.
    logic [WIDTH-1:0] prev_data = '0;
    logic             prev_req = 1'b0;
    logic             prev_rst = 1'b0;
    always @(negedge clk) begin
        if (rst_n && prev_rst && ch_data !== prev_data)
            check("data_stable", {30'd0, ch_req, prev_req}, 32'd2);
        prev_data = ch_data;
        prev_req  = ch_req;
        prev_rst  = rst_n;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [ADDR_W-1:0] r, input logic [PW-1:0] p, output bit acc);
        @(negedge clk);
        in_valid   = 1'b1;
        in_route   = r;
        in_payload = p;
        acc        = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc) exp_q.push_back({r, p});
    endtask

    task automatic wait_req(input logic v, input int budget, input string tag);
        int i = 0;
        while (ch_req !== v && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(ch_req), 32'(v));
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int i = 0;
        while (tx_count !== 16'(n) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(tx_count), 32'(16'(n)));
    endtask

    initial begin
        bit acc;
        int tx_before;
        int seen_before;
        int tries;
        bit saw_req;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req", 32'(ch_req), 32'd0);
        check("rst_data", 32'(ch_data), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(tx_count), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single packet, responder echoes after 2 clocks
        ack_block = 1'b0;
        push_word(3'b101, 8'hA5, acc);
        check("t1_acc", 32'(acc), 32'd1);
        @(posedge clk);
        #1;
        check("t1_req_latency", 32'(ch_req), 32'd1);
        check("t1_data", 32'(ch_data), 32'h5A5);
        exp_tx = 1;
        wait_tx(exp_tx, 60, "t1_tx_count");
        check("t1_req_low", 32'(ch_req), 32'd0);
        check("t1_ready", 32'(in_ready), 32'd1);
        repeat (5) @(negedge clk);
        check("t1_idle", 32'(ch_req), 32'd0);

        // 2: five back-to-back pushes with ack withheld
        ack_block = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_word(ADDR_W'(i), PW'(8'h30 + i), acc);
            check("t2_acc", 32'(acc), 32'(i < 4));
            if (i == 3) check("t2_full_ready", 32'(in_ready), 32'd0);
        end
        seen_before = seen;
        ack_block = 1'b0;
        exp_tx += 4;
        wait_tx(exp_tx, 200, "t2_tx_count");
        check("t2_seen", 32'(seen - seen_before), 32'd4);

        // 3: push coinciding with a completing pop at occupancy 2
        ack_block = 1'b1;
        push_word(3'd1, 8'h11, acc);
        push_word(3'd2, 8'h22, acc);
        wait_req(1'b1, 20, "t3_req_up");
        check("t3_head", 32'(ch_data), 32'(exp_q.pop_front()));
        @(negedge clk);
        man_ack = 1'b1;
        wait_req(1'b0, 20, "t3_req_down");
        man_ack = 1'b0;
        tx_before = exp_tx;
        @(posedge clk);
        @(posedge clk);
        check("t3_ready_before", 32'(in_ready), 32'd1);
        push_word(3'd3, 8'h33, acc);
        exp_tx++;
        check("t3_push_acc", 32'(acc), 32'd1);
        check("t3_pop_count", 32'(tx_count), 32'(16'(tx_before + 1)));
        check("t3_ready_after", 32'(in_ready), 32'd1);
        push_word(3'd4, 8'h44, acc);
        check("t3_fill1", 32'(acc), 32'd1);
        push_word(3'd5, 8'h55, acc);
        check("t3_fill2", 32'(acc), 32'd1);
        push_word(3'd6, 8'h66, acc);
        check("t3_full_refuse", 32'(acc), 32'd0);
        ack_block = 1'b0;
        exp_tx += 4;
        wait_tx(exp_tx, 200, "t3_tx_count");
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: reset in REQ with 3 words queued
        ack_block = 1'b1;
        push_word(3'd7, 8'h77, acc);
        push_word(3'd0, 8'h88, acc);
        push_word(3'd1, 8'h99, acc);
        wait_req(1'b1, 20, "t4_req_up");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_req_drop", 32'(ch_req), 32'd0);
        check("t4_ready", 32'(in_ready), 32'd1);
        check("t4_count", 32'(tx_count), 32'd0);
        check("t4_data", 32'(ch_data), 32'd0);
        exp_q.delete();
        exp_tx = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_req = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (ch_req) saw_req = 1'b1;
        end
        check("t4_no_req", 32'(saw_req), 32'd0);

`ifdef TX_TIMEOUT_EN
        // 6: ack never arrives, tx_err after TIMEOUT cycles in REQ
        push_word(3'd2, 8'hC3, acc);
        @(posedge clk);
        #1;
        check("t6_req", 32'(ch_req), 32'd1);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check("t6_err_early", 32'(tx_err), 32'd0);
        @(posedge clk);
        #1;
        check("t6_err_set", 32'(tx_err), 32'd1);
        check("t6_req_held", 32'(ch_req), 32'd1);
        ack_block = 1'b0;
        exp_tx++;
        wait_tx(exp_tx, 60, "t6_tx_count");
        check("t6_err_sticky", 32'(tx_err), 32'd1);
`endif

        // 5: 100 random packets with ack toggled off the clock grid
        async_mode = 1'b1;
        ack_block = 1'b0;
        seen_before = seen;
        for (int i = 0; i < 100; i++) begin
            logic [ADDR_W-1:0] r;
            logic [PW-1:0]     p;
            r = ADDR_W'($urandom);
            p = PW'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            tries = 0;
            acc = 1'b0;
            while (!acc && tries < 200) begin
                push_word(r, p, acc);
                tries++;
            end
            check("t5_push_acc", 32'(acc), 32'd1);
            if (acc) exp_tx++;
        end
        wait_tx(exp_tx, 5000, "t5_tx_count");
        check("t5_seen", 32'(seen - seen_before), 32'd100);
        check("t5_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef TX_TIMEOUT_EN
        check("final_err", 32'(tx_err), 32'd1);
`else
        check("final_err", 32'(tx_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
